// File: rtl/crypto_src_mux_if.sv
// Valid/ready bundle between the crypto operand producers, the source mux and the round/function units.
// The mux takes the slave modport; the producers/consumer side takes master.
interface crypto_src_mux_if #(
  parameter int WIDTH   = 128,
  parameter int NUM_SRC = 4
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic                     mode;
  logic [SEL_W-1:0]         select;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC-1:0]       src_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_src;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output mode, select, src_data, src_valid, out_ready,
    input  src_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  mode, select, src_data, src_valid, out_ready,
    output src_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/crypto_src_mux.sv
// Registered N-way operand source selector with fixed-select and round-robin arbitration.
// One output register with full backpressure.
module crypto_src_mux #(
  parameter int WIDTH   = 128,
  parameter int NUM_SRC = 4
) (
  input  logic            clk,
  input  logic            rst,
  crypto_src_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(NUM_SRC - 1);

  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   rr_idx;
  logic [SEL_W-1:0]   rr_cand;
  logic               rr_hit;
  logic               sel_ok;
  logic [NUM_SRC-1:0] grant;
  logic [SEL_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               out_free;
  logic               load;
  logic [WIDTH-1:0]   grant_word;

  logic [WIDTH-1:0]   data_p1;
  logic [SEL_W-1:0]   src_p1;
  logic               vld_p1;

  // Round-robin search begins one past the last granted source and wraps.
  always_comb begin
    rr_hit  = 1'b0;
    rr_idx  = rr_ptr;
    rr_cand = rr_ptr;
    for (int i = 1; i <= NUM_SRC; i++) begin
      rr_cand = SEL_W'((int'(rr_ptr) + i) % NUM_SRC);
      if (!rr_hit && bus.src_valid[rr_cand]) begin
        rr_hit = 1'b1;
        rr_idx = rr_cand;
      end
    end
  end

  // Fixed mode grants the selected source even when it is idle, so ready never depends on valid.
  always_comb begin
    sel_ok      = int'(bus.select) < NUM_SRC;
    grant       = '0;
    grant_idx   = bus.select;
    grant_valid = 1'b0;
    if (!bus.mode) begin
      if (sel_ok) begin
        grant[bus.select] = 1'b1;
        grant_valid       = bus.src_valid[bus.select];
      end
    end else begin
      grant_idx = rr_idx;
      if (rr_hit) begin
        grant[rr_idx] = 1'b1;
        grant_valid   = 1'b1;
      end
    end
  end

  assign out_free      = !vld_p1 || bus.out_ready;
  assign load          = out_free && grant_valid && !rst;
  assign grant_word    = bus.src_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign bus.src_ready = (out_free && !rst) ? grant : '0;

  // p1: output register and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      rr_ptr  <= LAST_SRC;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= grant_word;
      src_p1  <= grant_idx;
      rr_ptr  <= grant_idx;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_src   = src_p1;
  assign bus.out_valid = vld_p1;
endmodule

// File: tb/tb_crypto_src_mux.sv
// Scoreboard bench for crypto_src_mux: a 4-source instance driven through all modes,
// plus a 3-source instance for the out-of-range select case.
module tb_crypto_src_mux;
  localparam int W = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crypto_src_mux_if #(.WIDTH(W), .NUM_SRC(4)) bus ();
  crypto_src_mux_if #(.WIDTH(W), .NUM_SRC(3)) bus3 ();

  crypto_src_mux #(.WIDTH(W), .NUM_SRC(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  crypto_src_mux #(.WIDTH(W), .NUM_SRC(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] data;
  } sb_t;

  sb_t          sb[$];
  int           src_log[$];
  logic [W-1:0] word [4];
  logic         m_vld;
  logic [1:0]   m_rr;
  int           n_checks = 0;
  int           n_errors = 0;
  int           exp_log [18] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3, 0, 1, 0, 0, 1, 2};
  logic [W-1:0] bp_word;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive_words();
    bus.src_data = {word[3], word[2], word[1], word[0]};
  endtask

  task automatic model_grant(output logic gv, output logic [1:0] gi, output logic [3:0] gnt);
    logic [1:0] k;
    gv  = 1'b0;
    gi  = bus.select;
    gnt = '0;
    if (!bus.mode) begin
      gnt[bus.select] = 1'b1;
      gv = bus.src_valid[bus.select];
    end else begin
      for (int i = 1; i <= 4; i++) begin
        k = m_rr + 2'(i);
        if (!gv && bus.src_valid[k]) begin
          gv  = 1'b1;
          gi  = k;
          gnt = 4'b0001 << k;
        end
      end
    end
  endtask

  // One clock: check DUT against the model at negedge, then advance across the posedge.
  task automatic step();
    logic       gv, ok, ld;
    logic [1:0] gi;
    logic [3:0] gnt, exp_rdy;
    ld = 1'b0;
    gi = '0;
    @(negedge clk);
    if (rst) begin
      check_eq("rst_src_ready", W'(bus.src_ready), W'(4'b0000));
      m_vld = 1'b0;
      m_rr  = 2'd3;
      sb.delete();
    end else begin
      model_grant(gv, gi, gnt);
      ok      = !m_vld || bus.out_ready;
      exp_rdy = ok ? gnt : 4'b0000;
      ld      = ok && gv;
      check_eq("src_ready", W'(bus.src_ready), W'(exp_rdy));
      check_eq("out_valid", W'(bus.out_valid), W'(m_vld));
      if (m_vld) begin
        if (sb.size() == 0) begin
          check_eq("sb_size", W'(sb.size()), W'(1));
        end else begin
          check_eq("out_data", bus.out_data, sb[0].data);
          check_eq("out_src", W'(bus.out_src), W'(sb[0].src));
          if (bus.out_ready) begin
            src_log.push_back(int'(bus.out_src));
            void'(sb.pop_front());
          end
        end
      end
      if (ld) begin
        sb.push_back('{src: gi, data: word[gi]});
        m_rr = gi;
      end
      m_vld = ld ? 1'b1 : (bus.out_ready ? 1'b0 : m_vld);
    end
    @(posedge clk);
    #1;
    if (ld) begin
      word[gi] = word[gi] + 1'b1;
      drive_words();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.mode      = 1'b1;
    bus.select    = 2'd0;
    bus.src_valid = 4'hF;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) word[k] = W'(k + 1) << 120;
    drive_words();
    bus3.mode      = 1'b0;
    bus3.select    = 2'd0;
    bus3.src_valid = 3'b000;
    bus3.out_ready = 1'b1;
    bus3.src_data  = '0;
    m_vld = 1'b0;
    m_rr  = 2'd3;

    // Reset with every source valid
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_out_valid", W'(bus.out_valid), W'(1'b0));
    check_eq("rst_out_data", bus.out_data, W'(0));
    check_eq("rst_out_src", W'(bus.out_src), W'(0));
    src_log.delete();

    // Round-robin, all valid, then sources 1 and 3, then mode switch and back
    repeat (8) step();
    bus.src_valid = 4'b1010;
    repeat (4) step();
    bus.src_valid = 4'hF;
    repeat (2) step();
    bus.mode   = 1'b0;
    bus.select = 2'd0;
    repeat (2) step();
    bus.mode = 1'b1;
    repeat (2) step();
    bus.src_valid = 4'h0;
    step();
    check_eq("rr_log_len", W'(src_log.size()), W'(18));
    for (int i = 0; i < 18 && i < src_log.size(); i++)
      check_eq($sformatf("rr_seq%0d", i), W'(src_log[i]), W'(exp_log[i]));

    // Fixed select streaming from source 2
    bus.mode      = 1'b0;
    bus.select    = 2'd2;
    bus.src_valid = 4'hF;
    word[2]       = W'(1);
    drive_words();
    repeat (8) step();
    check_eq("stream_last", bus.out_data, W'(8));
    check_eq("stream_src", W'(bus.out_src), W'(2));

    // Backpressure holding a distinctive word
    bp_word = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    word[2] = bp_word;
    drive_words();
    step();
    bus.out_ready = 1'b0;
    repeat (3) begin
      step();
      check_eq("bp_hold", bus.out_data, bp_word);
    end
    bus.out_ready = 1'b1;
    step();
    check_eq("bp_resume_data", bus.out_data, bp_word + 1'b1);
    check_eq("bp_resume_vld", W'(bus.out_valid), W'(1'b1));

    // Selected source idle: nothing loads
    bus.select    = 2'd1;
    bus.src_valid = 4'b1101;
    repeat (2) step();
    check_eq("idle_sel_vld", W'(bus.out_valid), W'(1'b0));

    // Reset while a word is held
    bus.select    = 2'd0;
    bus.src_valid = 4'hF;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_vld", W'(bus.out_valid), W'(1'b0));
    step();
    bus.out_ready = 1'b1;
    step();
    bus.src_valid = 4'h0;
    repeat (2) step();
    check_eq("sb_drained", W'(sb.size()), W'(0));

    // Three-source build with out-of-range select
    bus3.select    = 2'd1;
    bus3.src_valid = 3'b111;
    bus3.src_data  = {W'(3), W'(2), W'(1)};
    @(posedge clk);
    #1;
    check_eq("n3_load_vld", W'(bus3.out_valid), W'(1'b1));
    check_eq("n3_load_data", bus3.out_data, W'(2));
    check_eq("n3_load_src", W'(bus3.out_src), W'(1));
    bus3.select = 2'd3;
    @(negedge clk);
    check_eq("n3_bad_ready", W'(bus3.src_ready), W'(3'b000));
    @(posedge clk);
    #1;
    check_eq("n3_drain_vld", W'(bus3.out_valid), W'(1'b0));
    check_eq("n3_hold_data", bus3.out_data, W'(2));
    @(negedge clk);
    check_eq("n3_bad_ready2", W'(bus3.src_ready), W'(3'b000));
    @(posedge clk);
    #1;
    check_eq("n3_still_idle", W'(bus3.out_valid), W'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
